// File: rtl/fp_intermediate_wb_arbiter.sv
// Intermediate writeback arbiter for the FPU: round-robin pick among the FP
// execution units' completed results, held in a single output register that
// feeds the FP writeback stage. Exception flags travel with the data.
module fp_intermediate_wb_arbiter #(
  parameter int NUM_WB_UNITS = 4,
  parameter int FLEN         = 64,
  parameter int ID_WIDTH     = 3,
  localparam int UW          = $clog2(NUM_WB_UNITS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WB_UNITS-1:0]        unit_done,
  input  logic [NUM_WB_UNITS*ID_WIDTH-1:0] unit_id,
  input  logic [NUM_WB_UNITS*FLEN-1:0]   unit_rd,
  input  logic [NUM_WB_UNITS*5-1:0]      unit_fflags,
  output logic [NUM_WB_UNITS-1:0]        unit_ack,
  output logic                           wb_done,
  input  logic                           wb_ack,
  output logic [ID_WIDTH-1:0]            wb_id,
  output logic [FLEN-1:0]                wb_rd,
  output logic [4:0]                     wb_fflags,
  output logic [UW-1:0]                  wb_unit
);

  logic [UW-1:0]       last_grant;
  logic [UW-1:0]       grant;
  logic                found;
  logic                load_ok;
  logic                load;
  int                  arb_idx;
  logic [ID_WIDTH-1:0] sel_id;
  logic [FLEN-1:0]     sel_rd;
  logic [4:0]          sel_fflags;

  // Round-robin search starting just after the last accepted grant, wrapping.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int k = 1; k <= NUM_WB_UNITS; k++) begin
      arb_idx = (int'(last_grant) + k) % NUM_WB_UNITS;
      if (!found && unit_done[arb_idx]) begin
        grant = UW'(arb_idx);
        found = 1'b1;
      end
    end
  end

  // Ack the granted unit only when the output register is empty or draining;
  // held low during reset so no unit retires a result that will be dropped.
  always_comb begin
    load_ok  = ~wb_done | wb_ack;
    unit_ack = '0;
    if (!rst && load_ok && found) begin
      unit_ack[grant] = 1'b1;
    end
    load = |unit_ack;
  end

  // Select the granted unit's payload from the packed source buses.
  always_comb begin
    sel_id     = unit_id[grant*ID_WIDTH +: ID_WIDTH];
    sel_rd     = unit_rd[grant*FLEN +: FLEN];
    sel_fflags = unit_fflags[grant*5 +: 5];
  end

  // Output register and round-robin pointer; pointer moves only on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_done    <= 1'b0;
      wb_id      <= '0;
      wb_rd      <= '0;
      wb_fflags  <= '0;
      wb_unit    <= '0;
      last_grant <= UW'(NUM_WB_UNITS - 1);
    end else if (load) begin
      wb_done    <= 1'b1;
      wb_id      <= sel_id;
      wb_rd      <= sel_rd;
      wb_fflags  <= sel_fflags;
      wb_unit    <= grant;
      last_grant <= grant;
    end else if (wb_ack) begin
      wb_done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_intermediate_wb_arbiter.sv
module tb_fp_intermediate_wb_arbiter;
  localparam int N  = 4;
  localparam int FL = 64;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    pend = '0;
  logic [N*IW-1:0] uid  = '0;
  logic [N*FL-1:0] urd  = '0;
  logic [N*5-1:0]  uff  = '0;
  logic [N-1:0]    unit_ack;
  logic            wb_done;
  logic            wb_ack = 1'b0;
  logic [IW-1:0]   wb_id;
  logic [FL-1:0]   wb_rd;
  logic [4:0]      wb_fflags;
  logic [1:0]      wb_unit;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [FL-1:0] rd;
    logic [4:0]    ff;
    logic [1:0]    u;
  } ent_t;

  ent_t q[$];
  logic m_held = 1'b0;
  int   m_ptr  = N - 1;
  logic [N-1:0] ack_seen;

  fp_intermediate_wb_arbiter #(.NUM_WB_UNITS(N), .FLEN(FL), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .unit_done(pend), .unit_id(uid), .unit_rd(urd), .unit_fflags(uff),
    .unit_ack(unit_ack),
    .wb_done(wb_done), .wb_ack(wb_ack), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_fflags(wb_fflags), .wb_unit(wb_unit)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present(int i, logic [IW-1:0] id, logic [FL-1:0] rd, logic [4:0] ff);
    pend[i] = 1'b1;
    uid[i*IW +: IW] = id;
    urd[i*FL +: FL] = rd;
    uff[i*5 +: 5]   = ff;
  endtask

  task automatic present_rand(int i);
    present(i, IW'($urandom), {$urandom, $urandom}, 5'($urandom));
  endtask

  // One clock cycle: reference model predicts the grant, compares unit_ack,
  // records the expected entry, and units retire whatever they saw acked.
  task automatic step();
    logic [N-1:0] exp_ack;
    int g;
    int u;
    exp_ack = '0;
    g = -1;
    @(negedge clk);
    if (!rst && (!m_held || wb_ack)) begin
      for (int k = 1; k <= N; k++) begin
        u = (m_ptr + k) % N;
        if (g < 0 && pend[u]) g = u;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("unit_ack", 64'(unit_ack), 64'(exp_ack));
    ack_seen = unit_ack;
    @(posedge clk);
    if (rst) m_held = 1'b0;
    else if (g >= 0) begin
      q.push_back(ent_t'{uid[g*IW +: IW], urd[g*FL +: FL], uff[g*5 +: 5], 2'(g)});
      m_ptr  = g;
      m_held = 1'b1;
    end else if (wb_ack) m_held = 1'b0;
    #1;
    for (int i = 0; i < N; i++) if (ack_seen[i]) pend[i] = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    chk("rst_wb_id", 64'(wb_id), 64'd0);
    chk("rst_wb_rd", wb_rd, 64'd0);
    chk("rst_wb_fflags", 64'(wb_fflags), 64'd0);
    chk("rst_wb_unit", 64'(wb_unit), 64'd0);
    chk("rst_unit_ack", 64'(unit_ack), 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    m_held = 1'b0;
    m_ptr  = N - 1;
    q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    wb_ack = 1'b1;
    for (int c = 0; c < 12 && (m_held || pend != '0); c++) step();
    chk("drain_idle", 64'({m_held, pend}), 64'd0);
  endtask

  // Monitor: pops an expected entry whenever the DUT presents a new result,
  // and otherwise requires held outputs to stay exactly stable.
  initial begin
    logic pd, pa;
    ent_t last, e;
    last = '0;
    forever begin
      @(negedge clk);
      pd = wb_done;
      pa = wb_ack;
      @(posedge clk);
      #2;
      chk("wb_done", 64'(wb_done), 64'(m_held));
      if (wb_done && (!pd || pa)) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual=unit%0d required=none at %0t", wb_unit, $time);
        end else begin
          e = q.pop_front();
          chk("wb_id", 64'(wb_id), 64'(e.id));
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_fflags", 64'(wb_fflags), 64'(e.ff));
          chk("wb_unit", 64'(wb_unit), 64'(e.u));
        end
        last = ent_t'{wb_id, wb_rd, wb_fflags, wb_unit};
      end else if (wb_done) begin
        chk("stall_id", 64'(wb_id), 64'(last.id));
        chk("stall_rd", wb_rd, last.rd);
        chk("stall_fflags", 64'(wb_fflags), 64'(last.ff));
        chk("stall_unit", 64'(wb_unit), 64'(last.u));
      end
    end
  end

  initial begin
    // Power-on reset
    @(posedge clk);
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();

    // Idle reset mid-cycle; no ack afterwards
    do_reset();
    step();
    step();

    // Single result from unit 2
    present(2, 3'd5, 64'h3FF0_0000_0000_0000, 5'b00001);
    wb_ack = 1'b1;
    step();
    step();
    step();

    // Round-robin from a fresh pointer with all units busy
    do_reset();
    for (int i = 0; i < N; i++) present_rand(i);
    wb_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < N; i++) if (!pend[i]) present_rand(i);
    end
    pend = '0;
    drain();

    // Backpressure: units 0 and 3, stall 3 cycles then release
    present_rand(0);
    present_rand(3);
    wb_ack = 1'b0;
    step();
    step();
    step();
    step();
    wb_ack = 1'b1;
    step();
    step();
    drain();

    // Pointer hold: grant unit 1, stall, then units 0 and 2 compete
    present_rand(1);
    wb_ack = 1'b0;
    step();
    present_rand(0);
    present_rand(2);
    step();
    step();
    wb_ack = 1'b1;
    step();
    step();
    drain();

    // Reset while holding unit 3 with unit 1 waiting
    present_rand(3);
    wb_ack = 1'b0;
    step();
    present_rand(1);
    step();
    do_reset();
    wb_ack = 1'b1;
    step();
    step();
    drain();

    // Randomized traffic with random backpressure and occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 9) < 4) present_rand(i);
      wb_ack = ($urandom_range(0, 3) != 0);
      step();
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    drain();
    step();
    #2;
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
